// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU.
// One quotient bit per clock; result is {remainder, quotient}.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   oprand1_i,
  input  logic [WIDTH-1:0]   oprand2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    ON,
    END
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shift;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  assign a_neg = signed_i & oprand1_i[WIDTH-1];
  assign b_neg = signed_i & oprand2_i[WIDTH-1];
  assign a_mag = a_neg ? -oprand1_i : oprand1_i;
  assign b_mag = b_neg ? -oprand2_i : oprand2_i;

  // dq holds the unconsumed dividend bits on the left
  // and the quotient bits shifting in from the right.
  assign shift    = {rem, dq[WIDTH-1]};
  assign q_bit    = shift >= {1'b0, dvs};
  assign rem_next = q_bit ? shift[WIDTH-1:0] - dvs
                          : shift[WIDTH-1:0];

  assign quo_fix = q_neg ? -dq : dq;
  assign rem_fix = r_neg ? -rem : rem;
  assign last    = cnt == CNT_W'(WIDTH);

  assign busy_o = (state == DIVZERO) || (state == ON);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dq       <= '0;
      rem      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          cnt      <= '0;
          if (start_i && !annul_i) begin
            if (oprand2_i == '0) begin
              state <= DIVZERO;
            end else begin
              dq    <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              state <= ON;
            end
          end
        end
        DIVZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            cnt     <= '0;
            ready_o <= 1'b0;
            state   <= IDLE;
          end else if (last) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            cnt      <= '0;
            state    <= END;
          end else begin
            rem <= rem_next;
            dq  <= {dq[WIDTH-2:0], q_bit};
            cnt <= cnt + CNT_W'(1);
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle 32-bit integer divider serving DIV/DIVU for the execute stage. EX launches an operation with start_i, holds the pipeline while busy_o is high, then takes the 64-bit {remainder, quotient} when ready_o asserts, to write HI/LO. It uses a radix-2 restoring algorithm, one quotient bit per clock. Its only storage is its internal state.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
oprand1_i  input  WIDTH  dividend; sampled with start_i.
oprand2_i  input  WIDTH  divisor; sampled with start_i.
start_i  input  1  request; level-held by EX until it has consumed the result.
annul_i  input  1  cancel; the current operation is discarded.
result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}; valid while ready_o=1.
ready_o  output  1  result valid.
busy_o  output  1  high in DIVZERO and ON states; EX stalls on it.

Behaviour:
- Reset (rst=0 at edge): state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. Reset has priority over every other input in every state, including mid-division.
- States: IDLE, DIVZERO, ON, END. busy_o is combinational from state.
- IDLE:
  - start_i=1, annul_i=0, divisor==0: go to DIVZERO.
  - start_i=1, annul_i=0, divisor!=0: latch operands, go to ON with counter=0.
    - If signed_i=1, latch two's-complement magnitudes of both operands.
    - Record the quotient sign as sign(a)^sign(b) and the remainder sign as sign(a).
  - Any other input combination: stay in IDLE. ready_o=0, result_o=0.
- DIVZERO: next edge goes to END with result_o=0 (quotient 0, remainder 0) and ready_o=1. If annul_i=1, go to IDLE instead.
- ON: each edge performs one iteration.
  - Shift the partial remainder left by 1, bringing in the next dividend MSB.
  - Trial subtract the divisor magnitude. If non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - counter increments each iteration.
  - After WIDTH iterations (counter==WIDTH), the next edge applies sign correction, registers result_o, sets ready_o=1 and moves to END.
  - Sign correction negates the quotient and/or remainder per the recorded signs; it applies only when signed=1.
  - annul_i=1 in ON: the next edge goes to IDLE with ready_o=0, counter=0 and the result discarded.
- Latency: start sampled at edge E0; iterations at E1..E32; result_o/ready_o valid after E33, i.e. 33 cycles. Divide-by-zero result is valid after E1.
- END: ready_o=1 and result_o held stable while start_i=1.
  - When start_i=0 at an edge, go to IDLE: ready_o=0, result_o=0.
  - annul_i=1 in END also goes to IDLE.
  - start_i remaining high in END never retriggers an operation; EX must drop start_i for at least one cycle first.
- Operand inputs and signed_i changing after E0 have no effect.
- Division semantics: truncation toward zero.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 (wraps; no trap).
  - Unsigned operations treat all 32 bits as magnitude.
- Simultaneous start_i and annul_i in IDLE: annul_i wins and no operation starts.

Test Plan:
- Unsigned 100/7 (signed_i=0), start held → busy_o for 33 cycles, then ready_o=1 with result_o=0x00000002_0000000E held until start_i drops; ready_o=0 one cycle after.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0, dividend 0x12345678 → ready_o=1 after 2 edges with result_o=0. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Start 0xFFFFFFFF/3 unsigned, assert annul_i at iteration 10 → IDLE next edge, ready_o never asserts. Then start 9/3 → result 0x00000000_00000003 after 33 cycles.
- rst=0 at iteration 20 → next edge all outputs 0 and busy_o=0. After rst=1, a fresh 50/5 completes normally: quotient 10, remainder 0.
- Hold start_i high across END for 10 cycles → result_o stable and no restart. Change oprand1_i during ON → result unaffected.
